// File: rtl/memoria_pkg.sv
// Shared types, default sizing and label lookup for the memory-pair turn sequencer.
package memoria_pkg;

    typedef enum logic [2:0] {
        PICK1 = 3'd0,
        PICK2 = 3'd1,
        CHECK = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } turn_state_t;

    localparam int DEF_N_CELLS        = 16;
    localparam int DEF_LABEL_W        = 4;
    localparam int DEF_HOLD_CYCLES    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000;

    // Labels are compared on a bus padded to the largest supported board.
    localparam int MAX_CELLS   = 16;
    localparam int MAX_LABEL_W = 8;
    localparam int MAX_IDX_W   = 4;

    function automatic logic [MAX_LABEL_W-1:0] label_at(
        input logic [MAX_CELLS*MAX_LABEL_W-1:0] labels,
        input logic [MAX_IDX_W-1:0]             idx
    );
        return labels[idx*MAX_LABEL_W +: MAX_LABEL_W];
    endfunction

endpackage

// File: rtl/memoria_delay_cnt.sv
// Clearable up-counter that stops at TERM-1 and flags reaching it; used for reveal hold and turn expiry.
module memoria_delay_cnt #(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CW = (TERM > 1) ? $clog2(TERM) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERM - 1);

    logic [CW-1:0] cnt_r;

    // Count while enabled, parking at the terminal value until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == LAST);

endmodule

// File: rtl/memoria_turn_ctrl.sv
// Turn sequencer: takes two picks, compares labels, drives cell select/par, scores and alternates players.
// Defining MEMORIA_TURN_TIMEOUT_EN adds a per-pick idle timeout that forfeits the turn.
module memoria_turn_ctrl
    import memoria_pkg::*;
#(
    parameter int N_CELLS        = DEF_N_CELLS,
    parameter int LABEL_W        = DEF_LABEL_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk_Temp,
    input  logic                         rst,
    input  logic                         sel_pulse,
    input  logic [$clog2(N_CELLS)-1:0]   cursor,
    input  logic [N_CELLS*LABEL_W-1:0]   labels,
    output logic [N_CELLS-1:0]           cell_select,
    output logic [N_CELLS-1:0]           cell_par,
    output logic                         player,
    output logic [3:0]                   score0,
    output logic [3:0]                   score1,
    output logic                         match_pulse,
    output logic                         turn_timeout,
    output logic                         game_over
);

    localparam int IDX_W = $clog2(N_CELLS);
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_CELLS);

    if ((N_CELLS % 2 != 0) || (N_CELLS < 2) || (N_CELLS > MAX_CELLS) || (LABEL_W < 1) ||
        (LABEL_W > MAX_LABEL_W) || (HOLD_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("memoria_turn_ctrl: unsupported parameter set");
    end

    turn_state_t state_r, state_s;

    logic [IDX_W-1:0]   idx_a_r, idx_a_s, idx_b_r, idx_b_s;
    logic [N_CELLS-1:0] sel_r, sel_s, par_r, par_s;
    logic               player_r, player_s;
    logic [3:0]         score0_r, score0_s, score1_r, score1_s;
    logic               hit_r, hit_s;
    logic               match_r, match_s;
    logic               tmo_r, tmo_s;
    logic               go_r, go_s;

    logic                              in_range_s, acc1_s, acc2_s, pick_acc_s;
    logic                              same_s, hold_done_s, hold_clr_s, hold_en_s, tmo_fire_s;
    logic [MAX_CELLS*MAX_LABEL_W-1:0]  lab_pad_s;

    assign in_range_s = ({1'b0, cursor} < N_LIM);
    assign acc1_s     = (state_r == PICK1) && sel_pulse && in_range_s && !par_r[cursor];
    assign acc2_s     = (state_r == PICK2) && sel_pulse && in_range_s && !par_r[cursor] &&
                        (cursor != idx_a_r);
    assign pick_acc_s = acc1_s || acc2_s;

    // Spread labels onto the padded layout that label_at understands.
    always_comb begin
        lab_pad_s = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            lab_pad_s[i*MAX_LABEL_W +: LABEL_W] = labels[i*LABEL_W +: LABEL_W];
        end
    end

    assign same_s = (label_at(lab_pad_s, MAX_IDX_W'(idx_a_r)) ==
                     label_at(lab_pad_s, MAX_IDX_W'(idx_b_r)));

    assign hold_clr_s = (state_r != HOLD);
    assign hold_en_s  = (state_r == HOLD);

    memoria_delay_cnt #(.TERM(HOLD_CYCLES)) u_hold_cnt (
        .clk  (clk_Temp),
        .rst  (rst),
        .clr  (hold_clr_s),
        .en   (hold_en_s),
        .done (hold_done_s)
    );

`ifdef MEMORIA_TURN_TIMEOUT_EN
    logic in_pick_s, tmo_clr_s, tmo_done_s;

    assign in_pick_s  = (state_r == PICK1) || (state_r == PICK2);
    assign tmo_fire_s = in_pick_s && tmo_done_s && !pick_acc_s;
    assign tmo_clr_s  = !in_pick_s || pick_acc_s || tmo_fire_s;

    memoria_delay_cnt #(.TERM(TIMEOUT_CYCLES)) u_tmo_cnt (
        .clk  (clk_Temp),
        .rst  (rst),
        .clr  (tmo_clr_s),
        .en   (in_pick_s),
        .done (tmo_done_s)
    );
`else
    assign tmo_fire_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_Temp) begin
        if (rst) begin
            state_r <= PICK1;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an accepted pick takes priority over an expiring turn.
    always_comb begin
        state_s = state_r;
        case (state_r)
            PICK1: begin
                if (acc1_s) state_s = PICK2;
                else        state_s = PICK1;
            end
            PICK2: begin
                if (acc2_s)          state_s = CHECK;
                else if (tmo_fire_s) state_s = PICK1;
                else                 state_s = PICK2;
            end
            CHECK: state_s = HOLD;
            HOLD: begin
                if (!hold_done_s)          state_s = HOLD;
                else if (hit_r && &par_r)  state_s = DONE;
                else                       state_s = PICK1;
            end
            DONE:    state_s = DONE;
            default: state_s = PICK1;
        endcase
    end

    // Next values for the registered board, score and pulse outputs.
    always_comb begin
        idx_a_s  = idx_a_r;
        idx_b_s  = idx_b_r;
        sel_s    = sel_r;
        par_s    = par_r;
        player_s = player_r;
        score0_s = score0_r;
        score1_s = score1_r;
        hit_s    = hit_r;
        match_s  = 1'b0;
        tmo_s    = 1'b0;
        go_s     = go_r;
        case (state_r)
            PICK1, PICK2: begin
                if (acc1_s) begin
                    idx_a_s        = cursor;
                    sel_s[cursor]  = 1'b1;
                end else if (acc2_s) begin
                    idx_b_s        = cursor;
                    sel_s[cursor]  = 1'b1;
                end else if (tmo_fire_s) begin
                    sel_s    = par_r;
                    player_s = ~player_r;
                    tmo_s    = 1'b1;
                end else begin
                    sel_s = sel_r;
                end
            end
            CHECK: begin
                hit_s = same_s;
                if (same_s) begin
                    par_s[idx_a_r] = 1'b1;
                    par_s[idx_b_r] = 1'b1;
                    match_s        = 1'b1;
                    if (player_r) score1_s = (score1_r == 4'd15) ? 4'd15 : score1_r + 4'd1;
                    else          score0_s = (score0_r == 4'd15) ? 4'd15 : score0_r + 4'd1;
                end else begin
                    match_s = 1'b0;
                end
            end
            HOLD: begin
                if (hold_done_s && hit_r && &par_r) begin
                    sel_s = '1;
                    go_s  = 1'b1;
                end else if (hold_done_s && !hit_r) begin
                    sel_s    = par_r;
                    player_s = ~player_r;
                end else begin
                    sel_s = sel_r;
                end
            end
            DONE: begin
                sel_s = '1;
                go_s  = 1'b1;
            end
            default: begin
                sel_s = sel_r;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk_Temp) begin
        if (rst) begin
            idx_a_r  <= '0;
            idx_b_r  <= '0;
            sel_r    <= '0;
            par_r    <= '0;
            player_r <= 1'b0;
            score0_r <= 4'd0;
            score1_r <= 4'd0;
            hit_r    <= 1'b0;
            match_r  <= 1'b0;
            tmo_r    <= 1'b0;
            go_r     <= 1'b0;
        end else begin
            idx_a_r  <= idx_a_s;
            idx_b_r  <= idx_b_s;
            sel_r    <= sel_s;
            par_r    <= par_s;
            player_r <= player_s;
            score0_r <= score0_s;
            score1_r <= score1_s;
            hit_r    <= hit_s;
            match_r  <= match_s;
            tmo_r    <= tmo_s;
            go_r     <= go_s;
        end
    end

    assign cell_select  = sel_r;
    assign cell_par     = par_r;
    assign player       = player_r;
    assign score0       = score0_r;
    assign score1       = score1_r;
    assign match_pulse  = match_r;
    assign turn_timeout = tmo_r;
    assign game_over    = go_r;

endmodule
